// File: rtl/tanh_arbiter.sv
// tanh_arbiter: shares one tanh engine between N requesters.
// A round-robin arbiter picks one pending request, launches the engine with
// that requester's operand, waits for the engine to finish, then returns the
// result with a one-cycle ack to the winner. A watchdog aborts engine
// operations that run too long.
//
// Handshake: a requester raises req[i] with x_in[i] stable and holds both
// until it sees ack[i] (one cycle). y_out is valid in the ack cycle. Toward
// the engine, eng_start pulses once with eng_x stable. eng_ready then drops
// while computing and rises again with eng_y valid.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req, x_in       per-requester request level and operand
//   ack, y_out      one-hot completion pulse, result
//   err             sticky watchdog-timeout flag
//   busy            high whenever the FSM is not IDLE
//   eng_start/eng_x engine launch pulse and operand
//   eng_ready/eng_y engine idle/done level and result
//   dbg_state       current FSM state, for observation
module tanh_arbiter #(
   parameter int N       = 4,
   parameter int XW      = 8,
   parameter int RW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*XW-1:0] x_in,
   output logic [N-1:0]    ack,
   output logic [RW-1:0]   y_out,
   output logic            err,
   output logic            busy,
   output logic            eng_start,
   output logic [XW-1:0]   eng_x,
   input  logic            eng_ready,
   input  logic [RW-1:0]   eng_y,
   output logic [2:0]      dbg_state
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_LOW  = 3'd2,
      S_WAIT_HIGH = 3'd3,
      S_DONE      = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [XW-1:0]   x_q, x_d;
   logic [RW-1:0]   y_q, y_d;
   logic            err_q, err_d;
   logic [7:0]      cnt_q, cnt_d;

   logic            grant_vld;
   logic [IW-1:0]   grant_idx;

   // Round-robin search starting one past the last served requester.
   always_comb begin : arb
      int j;
      j         = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr_q) + k) % N;
         if (!grant_vld && req[j]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            // No grant while the engine is still busy (e.g. after a reset
            // or a watchdog abort left it computing).
            if (grant_vld && eng_ready) begin
               idx_d   = grant_idx;
               x_d     = x_in[int'(grant_idx)*XW +: XW];
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW, S_WAIT_HIGH: begin
            if (cnt_q == WD_LIMIT) begin
               // Abort: report a zero result and still ack the requester.
               err_d   = 1'b1;
               y_d     = '0;
               state_d = S_DONE;
            end else begin
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               if (state_q == S_WAIT_LOW) begin
                  if (!eng_ready) state_d = S_WAIT_HIGH;
               end else if (eng_ready) begin
                  y_d     = eng_y;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            ptr_d   = idx_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= IW'(N - 1);
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decoded from state so a reset clears them immediately.
   always_comb begin : outs
      ack = '0;
      if (state_q == S_DONE) ack[idx_q] = 1'b1;
   end

   assign eng_start = (state_q == S_LAUNCH);
   assign busy      = (state_q != S_IDLE);
   assign eng_x     = x_q;
   assign y_out     = y_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: doc/tanh_arbiter.md
TANH_ARBITER -- requirements
Module: tanh_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one tanh engine.
REQ-002 Parameter XW, default 8, operand width.
REQ-003 Parameter RW, default 16, result width.
REQ-004 Parameter TIMEOUT, default 255, max engine busy cycles before abort (8-bit watchdog).
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-007 req  in  N  per-requester request level; held high until that requester's ack.
REQ-008 x_in  in  N*XW  operands; requester i at bits [i*XW +: XW], held stable while req[i]=1.
REQ-009 ack  out  N  one-hot, one-cycle completion pulse to the served requester.
REQ-010 y_out  out  RW  result; valid in the cycle ack is high, held until next capture.
REQ-011 err  out  1  sticky watchdog-timeout flag.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 eng_start  out  1  one-cycle start pulse to the tanh engine.
REQ-014 eng_x  out  XW  operand to the engine, held stable from LAUNCH until return to IDLE.
REQ-015 eng_ready  in  1  engine idle/done level (high when idle, low while computing).
REQ-016 eng_y  in  RW  engine result, valid when eng_ready returns high.

Function
REQ-017 FSM states IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, DONE; encoding implementer's choice.
REQ-018 IDLE: if |req and eng_ready=1, select winner, latch index into idx and its operand into eng_x register, go LAUNCH; else stay.
REQ-019 Arbitration round-robin: search starts at (ptr+1) mod N, first set req bit wins; ptr updated to idx in DONE only.
REQ-020 LAUNCH: eng_start=1 for exactly this cycle; clear watchdog counter; go WAIT_LOW.
REQ-021 WAIT_LOW: stay while eng_ready=1; on eng_ready=0 go WAIT_HIGH.
REQ-022 WAIT_HIGH: stay while eng_ready=0; on eng_ready=1 capture eng_y into y_out, go DONE.
REQ-023 DONE: ack[idx]=1 for this cycle only, ptr<=idx, go IDLE.
REQ-024 Latency: req sampled in IDLE at cycle T -> eng_start at T+1; ack one cycle after eng_ready returns high.
REQ-025 Watchdog: counter increments each cycle in WAIT_LOW/WAIT_HIGH, saturating; on reaching TIMEOUT set err, y_out<=0, go DONE (ack still issued).
REQ-026 err remains 1 until reset; arbiter continues serving after timeout.
REQ-027 Requests arriving while busy are not lost; they are arbitrated on the next IDLE cycle.
REQ-028 req[idx] falling before ack: transaction completes, ack still pulsed.
REQ-029 eng_ready=0 in IDLE: no grant, no eng_start, until eng_ready=1.
REQ-030 At most one ack bit high per cycle; ack and eng_start never high in the same cycle.

Reset
REQ-031 rst=0: state=IDLE, ptr=N-1 (requester 0 has first priority), idx=0, eng_x reg=0, y_out=0, ack=0, eng_start=0, err=0, busy=0, counter=0.
REQ-032 Reset mid-transaction aborts without ack; after release the engine is regranted only once eng_ready=1.

Verification
REQ-033 Single request: req=4'b0001, x_in[7:0]=8'h40, engine model ready low 5 cycles returning 16'h3A00 -> eng_start one cycle after req, eng_x=8'h40, ack=4'b0001 with y_out=16'h3A00.
REQ-034 Round robin: req=4'b1111 held, each op returns i -> ack order 0,1,2,3,0, ack always one-hot.
REQ-035 Late request: req[2] raised during requester 1's WAIT_HIGH -> served immediately after ack[1], no cycle lost beyond IDLE.
REQ-036 Timeout: engine holds eng_ready=0 forever, TIMEOUT=255 -> err=1 and ack pulse with y_out=0 about 256 cycles after eng_start; next request still served.
REQ-037 Reset mid-op: rst=0 during WAIT_HIGH -> all outputs zero at once, no ack; after release, req[0]=1 served first.
REQ-038 Engine not ready: eng_ready=0 while req=4'b0010 in IDLE -> no eng_start until eng_ready=1, then normal service.
